fetch_unit: RTL and testbench

Instruction fetch stage that produces the 32-bit instruction stream consumed by the decode stage. It keeps the fetch PC and issues word-aligned requests to instruction memory over a request/grant + in-order response interface. Responses are buffered in a small FIFO and presented to decode with a valid/ready handshake. A redirect (branch/jump target) flushes buffered and in-flight instructions.

---
 rtl/fetch_unit_if.sv | 30 +++
 rtl/fetch_unit.sv | 124 ++++++++++++
 tb/tb_fetch_unit.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Fetch stage bundle: imem request/grant/response channel, redirect, and decode valid/ready.
interface fetch_unit_if;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;

    modport master (
        output imem_req_o, imem_addr_o,
        input  imem_gnt_i, imem_rvalid_i, imem_rdata_i,
        input  redirect_i, redirect_pc_i,
        output instr_valid_o, instr_o, pc_o,
        input  instr_ready_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o,
        output imem_gnt_i, imem_rvalid_i, imem_rdata_i,
        output redirect_i, redirect_pc_i,
        input  instr_valid_o, instr_o, pc_o,
        output instr_ready_i
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: word-aligned imem requests, in-order responses buffered for decode (response cycle N -> valid N+1).
// Backpressure: requests stop while outstanding + buffered reaches BUF_DEPTH; redirect flushes buffer and in-flight words.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_unit_if.master bus
);
    localparam int            CW      = $clog2(BUF_DEPTH + 1);
    localparam int            AW      = $clog2(BUF_DEPTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_MAX = CW'(BUF_DEPTH);
    localparam logic [CW:0]   CREDITS = (CW + 1)'(BUF_DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [31:0]   NOP     = 32'h0000_0013;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [31:0]   buf_pc_q    [BUF_DEPTH];
    logic [31:0]   buf_instr_q [BUF_DEPTH];

    logic [31:0] redirect_pc;
    logic [CW:0] in_use;
    logic        grant, push, pop, instr_vld;

    assign redirect_pc = {bus.redirect_pc_i[31:2], 2'b00};
    assign in_use      = {1'b0, outst_q} + {1'b0, count_q};

    assign bus.imem_req_o  = rst_n && !bus.redirect_i && (in_use < CREDITS);
    assign bus.imem_addr_o = fetch_pc_q;
    assign grant           = bus.imem_req_o && bus.imem_gnt_i;

    assign instr_vld = (count_q != '0);
    assign push      = bus.imem_rvalid_i && (discard_q == '0) && !bus.redirect_i;
    assign pop       = instr_vld && bus.instr_ready_i && !bus.redirect_i;

    assign bus.instr_valid_o = instr_vld;
    assign bus.instr_o       = instr_vld ? buf_instr_q[rd_ptr_q] : NOP;
    assign bus.pc_o          = instr_vld ? buf_pc_q[rd_ptr_q] : '0;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        outst_d    = outst_q;
        discard_d  = discard_q;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;

        if (grant) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
        if (grant && !bus.imem_rvalid_i) begin
            outst_d = outst_q + CNT_ONE;
        end else if (!grant && bus.imem_rvalid_i) begin
            outst_d = outst_q - CNT_ONE;
        end
        if (bus.imem_rvalid_i && (discard_q != '0)) begin
            discard_d = discard_q - CNT_ONE;
        end

        if (push) begin
            resp_pc_d = resp_pc_q + 32'd4;
            wr_ptr_d  = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (push && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (pop && !push) begin
            count_d = count_q - CNT_ONE;
        end

        // Discard never exceeds outstanding, so every word still in flight after
        // this edge (older discards included) is exactly the new discard count.
        if (bus.redirect_i) begin
            fetch_pc_d = redirect_pc;
            resp_pc_d  = redirect_pc;
            discard_d  = outst_d;
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            outst_q    <= '0;
            discard_q  <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // Payload needs no reset: the head is only visible while count_q != 0.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_pc_q[wr_ptr_q]    <= resp_pc_q;
            buf_instr_q[wr_ptr_q] <= bus.imem_rdata_i;
        end
    end

    assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && (count_q == CNT_MAX)));
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboarded bench for fetch_unit: imem model with variable latency/grant, decode sink, redirect and reset scenarios.
module tb_fetch_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_unit_if bus ();
    fetch_unit_if wbus ();

    fetch_unit #(.RESET_PC(32'h0000_0100), .BUF_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .BUF_DEPTH(4)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .bus(wbus)
    );

    typedef struct { logic [31:0] addr; int due; } rsp_t;
    typedef struct { logic [31:0] pc; int n; } redir_t;

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          lat = 1;
    bit          gnt_rand = 1'b0;
    bit          ready_en = 1'b1;
    bit          tput_chk = 1'b1;
    int          first_pop_cyc = -1;
    int          last_pop_cyc = 0;
    int          rel_cyc = 0;
    int          grant_cnt = 0;
    bit          prev_pend = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [31:0] exp_addr = 32'h0000_0100;
    rsp_t        rsp_q[$];
    redir_t      redir_q[$];
    logic [31:0] exp_pc_q[$];
    logic [31:0] wrap_exp[3] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};

    function automatic logic [31:0] mk_instr(logic [31:0] pc);
        return pc ^ 32'h5A5A_0013;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_stream(logic [31:0] base, int n);
        for (int i = 0; i < n; i++) exp_pc_q.push_back(base + 32'(4 * i));
    endtask

    task automatic tick();
        @(negedge clk);
        #3;
    endtask

    task automatic do_redirect(logic [31:0] pc, int n);
        redir_q.push_back('{pc, n});
        for (int k = 0; k < 10 && redir_q.size() > 0; k++) tick();
    endtask

    task automatic wait_drain(int budget);
        int k;
        k = 0;
        while (exp_pc_q.size() > 0 && k < budget) begin
            tick();
            k++;
        end
        n_chk++;
        if (exp_pc_q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d instructions still expected after %0d cycles, required 0",
                     exp_pc_q.size(), budget);
        end
    endtask

    // Memory + redirect driver; request-side checks happen once inputs settle.
    always @(negedge clk) begin
        rsp_t   r;
        redir_t d;
        cyc++;
        if (!rst_n) begin
            rsp_q.delete();
            bus.imem_rvalid_i = 1'b0;
            bus.imem_gnt_i    = 1'b1;
            bus.redirect_i    = 1'b0;
            bus.instr_ready_i = 1'b0;
            prev_pend         = 1'b0;
            exp_addr          = 32'h0000_0100;
        end else begin
            bus.redirect_i = 1'b0;
            if (redir_q.size() > 0) begin
                d = redir_q.pop_front();
                bus.redirect_i    = 1'b1;
                bus.redirect_pc_i = d.pc;
                exp_pc_q.delete();
                push_stream({d.pc[31:2], 2'b00}, d.n);
                exp_addr = {d.pc[31:2], 2'b00};
            end
            bus.imem_rvalid_i = 1'b0;
            bus.imem_rdata_i  = '0;
            if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
                r = rsp_q.pop_front();
                bus.imem_rvalid_i = 1'b1;
                bus.imem_rdata_i  = mk_instr(r.addr);
            end
            bus.imem_gnt_i    = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.instr_ready_i = ready_en && (exp_pc_q.size() > 0);
            #1;
            if (prev_pend && !bus.redirect_i) begin
                check("req_held", 32'(bus.imem_req_o), 32'd1);
                check("addr_stable", bus.imem_addr_o, prev_addr);
            end
            if (bus.imem_req_o && bus.imem_gnt_i) begin
                check("req_addr", bus.imem_addr_o, exp_addr);
                exp_addr += 32'd4;
                grant_cnt++;
                rsp_q.push_back('{bus.imem_addr_o, cyc + lat});
            end
            prev_pend = bus.imem_req_o && !bus.imem_gnt_i;
            prev_addr = bus.imem_addr_o;
        end
    end

    // Monitor: every accepted instruction must be the scoreboard head.
    always @(negedge clk) begin
        logic [31:0] e;
        #2;
        if (rst_n && bus.instr_valid_o && bus.instr_ready_i && !bus.redirect_i) begin
            if (exp_pc_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_instr: got pc %h, expected none", bus.pc_o);
            end else begin
                e = exp_pc_q.pop_front();
                check("pop_pc", bus.pc_o, e);
                check("pop_instr", bus.instr_o, mk_instr(e));
                if (tput_chk) begin
                    if (first_pop_cyc < 0) first_pop_cyc = cyc;
                    else check("tput_gap", 32'(cyc - last_pop_cyc), 32'd1);
                end
                last_pop_cyc = cyc;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.imem_gnt_i     = 1'b1;
        bus.imem_rvalid_i  = 1'b0;
        bus.imem_rdata_i   = '0;
        bus.redirect_i     = 1'b0;
        bus.redirect_pc_i  = '0;
        bus.instr_ready_i  = 1'b0;
        wbus.imem_gnt_i    = 1'b1;
        wbus.imem_rvalid_i = 1'b0;
        wbus.imem_rdata_i  = '0;
        wbus.redirect_i    = 1'b0;
        wbus.redirect_pc_i = '0;
        wbus.instr_ready_i = 1'b0;

        // Reset state and startup at 0x100, latency 1
        push_stream(32'h0000_0100, 10);
        repeat (3) tick();
        check("rst_req", 32'(bus.imem_req_o), 32'd0);
        check("rst_valid", 32'(bus.instr_valid_o), 32'd0);
        check("rst_instr", bus.instr_o, 32'h0000_0013);
        check("rst_pc", bus.pc_o, 32'd0);
        check("rst_wrap_req", 32'(wbus.imem_req_o), 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            if (i == 0) begin
                rel_cyc = cyc;
                check("first_req", 32'(bus.imem_req_o), 32'd1);
                check("first_addr", bus.imem_addr_o, 32'h0000_0100);
                check("startup_instr_nop", bus.instr_o, 32'h0000_0013);
            end
            check("wrap_req", 32'(wbus.imem_req_o), 32'd1);
            check("wrap_addr", wbus.imem_addr_o, wrap_exp[i]);
        end
        wait_drain(100);
        check("first_valid_latency", 32'(first_pop_cyc - rel_cyc), 32'd2);
        tput_chk = 1'b0;
        repeat (8) tick();

        // Decode stall: exactly four requests, then drain and resume at +16
        ready_en = 1'b0;
        do_redirect(32'h0000_0300, 12);
        grant_cnt = 0;
        repeat (10) tick();
        check("stall_grants", 32'(grant_cnt), 32'd4);
        check("stall_req_low", 32'(bus.imem_req_o), 32'd0);
        ready_en = 1'b1;
        wait_drain(100);
        repeat (8) tick();

        // Random grant backpressure
        gnt_rand = 1'b1;
        lat = 2;
        do_redirect(32'h0000_1000, 16);
        wait_drain(400);
        gnt_rand = 1'b0;
        repeat (8) tick();

        // Redirect with exactly two requests in flight, latency 3
        lat = 3;
        do_redirect(32'h0000_0500, 8);
        repeat (2) tick();
        do_redirect(32'h0000_2003, 6);
        tick();
        check("discard_two_in_flight", 32'(dut.discard_q), 32'd2);
        check("valid_after_redirect", 32'(bus.instr_valid_o), 32'd0);
        wait_drain(100);
        repeat (8) tick();

        // Back-to-back redirects coinciding with rvalid and pop, latency 2
        lat = 2;
        do_redirect(32'h0000_0600, 20);
        repeat (8) tick();
        redir_q.push_back('{32'h0000_0040, 8});
        redir_q.push_back('{32'h0000_0080, 8});
        tick();
        check("redir_with_rvalid", 32'(bus.imem_rvalid_i), 32'd1);
        check("redir_with_pop", 32'(bus.instr_valid_o && bus.instr_ready_i), 32'd1);
        tick();
        check("second_redirect_pc", bus.redirect_pc_i, 32'h0000_0080);
        tick();
        check("discard_after_b2b", 32'(dut.discard_q), 32'd0);
        wait_drain(100);
        repeat (8) tick();
        check("discard_zero", 32'(dut.discard_q), 32'd0);

        // Asynchronous reset mid-stream, then restart at RESET_PC
        lat = 1;
        do_redirect(32'h0000_0700, 30);
        repeat (6) tick();
        @(posedge clk);
        #2;
        check("pre_reset_valid", 32'(bus.instr_valid_o), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_req", 32'(bus.imem_req_o), 32'd0);
        check("async_rst_valid", 32'(bus.instr_valid_o), 32'd0);
        check("async_rst_instr", bus.instr_o, 32'h0000_0013);
        check("async_rst_pc", bus.pc_o, 32'd0);
        exp_pc_q.delete();
        push_stream(32'h0000_0100, 5);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        wait_drain(100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
